dram_backing_store: RTL and testbench
=====================================

Name: dram_backing_store

Overview:
- Behavioural/synthesizable DRAM model that answers the L2's backing-store request port (valid/write/addr/wdata out of L2, rdata/ready back into L2).
- Accepts one 128-bit line request at a time and holds it internally after dram_valid drops. Applies a programmable fixed latency, then returns a single-cycle dram_ready pulse.
- Sits below the L2 in the coherence testbench and top level. It replaces the ad-hoc memory stub.

Parameters:
- DEPTH_LOG2, 10: number of line-index bits; store holds 2^DEPTH_LOG2 lines of 128 bits.
- RD_LATENCY, 4: cycles from read acceptance to dram_ready; must be >= 1 (elaboration error otherwise).
- WR_LATENCY, 2: cycles from write acceptance to dram_ready; must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dram_valid  in  1  request strobe from L2
- dram_write  in  1  1 = write line, 0 = read line
- dram_addr  in  32  byte address; bits [3:0] ignored
- dram_wdata  in  128  write line data
- dram_rdata  out  128  read line data
- dram_ready  out  1  one-cycle completion pulse (reads and writes)
- busy  out  1  high while a request is held (BUSY or RESP state)
- rd_count  out  16  accepted reads, saturating
- wr_count  out  16  accepted writes, saturating
- alias_err  out  1  sticky flag: an accepted address had nonzero bits [31:4+DEPTH_LOG2]

Behaviour:
- Clock and reset: clk; reset is synchronous and active-high.
- Reset values: dram_ready=0, dram_rdata=0, busy=0, rd_count=0, wr_count=0, alias_err=0, state=IDLE. The per-line written bitmap is cleared. Storage array contents are not reset.
- Line indexing: index = dram_addr[4 +: DEPTH_LOG2]. The block address is {dram_addr[31:4],4'b0}.
- FSM states are IDLE, BUSY and RESP.
  - IDLE: if dram_valid=1 at a rising edge, the request is accepted. The edge latches op, index and block address, loads the latency counter with (write ? WR_LATENCY : RD_LATENCY) - 1, and moves to BUSY (or to RESP if the latency is 1). Counters and alias_err update at this same edge.
  - Write commit: data is written into the array and the bitmap bit is set at the acceptance edge.
  - BUSY: the counter decrements each cycle. When it reaches 0 the FSM moves to RESP.
  - RESP: dram_ready=1 for exactly this cycle, then the FSM returns to IDLE.
- Read data: for a read, dram_rdata is loaded on entry to RESP. It holds that value until the next read's RESP. Writes do not change dram_rdata.
- Latency: if dram_valid is high in cycle 0 (IDLE), dram_ready is high in cycle L, where L is RD_LATENCY or WR_LATENCY.
- Read source: a read of a line whose bitmap bit is 0 returns the pattern {4{block address}}. Otherwise it returns the stored line.
- Ignored requests: dram_valid is ignored in BUSY and RESP, including the RESP cycle itself. Minimum request spacing is L+1 cycles. dram_write and dram_wdata are sampled only at acceptance.
- Repeated valid: dram_valid still high in the IDLE cycle after RESP is accepted as a new request. A repeated write of the same data is idempotent.
- Counters: rd_count and wr_count saturate at 16'hFFFF and never wrap.
- Reset mid-operation: the held request is aborted and no dram_ready is issued. A write already committed is discarded because the bitmap is cleared, so its line reads back as the pattern.
- X handling: an X on dram_valid is treated as 0. X write data is stored as 0.

Decomposition:
- Package dram_pkg holds:
  - state enum {IDLE, BUSY, RESP};
  - constants LINE_BITS=128, LINE_OFS_BITS=4;
  - function line_pattern(addr), which returns {4{addr[31:4],4'b0}}.
- Sub-module dram_line_store holds the array plus the written bitmap. It has:
  - a write port with bitmap set;
  - a combinational read with pattern fallback;
  - a bitmap clear on reset.
- The top level keeps the FSM, the latency counter and the statistics.

Test Plan:
- Read 0x0000_1230 after reset, RD_LATENCY=4, valid high in cycle 0 only → dram_ready high in cycle 4 only; dram_rdata=128'h00001230_00001230_00001230_00001230; rd_count=1.
- Write 0x40 with data 128'hDEADBEEF_0..0_CAFEF00D (WR_LATENCY=2), then read 0x4C → write ready in cycle 2; read returns 128'hDEADBEEF_0..0_CAFEF00D; wr_count=1, rd_count=1.
- Issue a read, then pulse valid again during BUSY and during RESP → both pulses ignored; exactly one ready; rd_count=1.
- Hold valid continuously with write=1, addr 0x80 → one accept every 3 cycles (WR_LATENCY=2); wr_count increments each time; data unchanged.
- Write 0x100, then assert reset for 1 cycle while a read of 0x100 is in BUSY → no ready; all outputs 0; a subsequent read of 0x100 returns the pattern 128'h00000100_00000100_00000100_00000100.
- Read 0x0001_0010 with DEPTH_LOG2=10 → alias_err=1 and stays 1; returns the pattern for 0x0001_0010 (index 1 unwritten).

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and helpers for the DRAM backing-store model that sits below the L2.
// Line geometry is fixed at 128-bit lines addressed on 16-byte boundaries.
package dram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dram_state_t;

  localparam int LINE_BITS     = 128;
  localparam int LINE_OFS_BITS = 4;

  // Fill pattern for lines never written: the block address replicated four times.
  function automatic logic [LINE_BITS-1:0] line_pattern(input logic [31:0] addr);
    logic [31:0] blk;
    blk = addr & ~32'h0000_000F;
    return {4{blk}};
  endfunction

endpackage

// File: rtl/dram_line_store.sv
// Line storage for the DRAM model: data array plus a per-line "written" bitmap.
// Reads are combinational; unwritten lines return the block-address pattern.
module dram_line_store
  import dram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DEPTH_LOG2-1:0]         wr_index,
  input  logic [LINE_BITS-1:0]          wr_data,
  input  logic [31-LINE_OFS_BITS:0]     rd_block,
  output logic [LINE_BITS-1:0]          rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [LINE_BITS-1:0] line_mem [DEPTH];
  logic [DEPTH-1:0]     written_reg;
  logic [LINE_BITS-1:0] wr_data_clean;
  logic [DEPTH_LOG2-1:0] rd_index;

  // Unknown write bits are stored as 0 so later reads never return X.
  for (genvar gi = 0; gi < LINE_BITS; gi++) begin : g_clean
    assign wr_data_clean[gi] = (wr_data[gi] === 1'b1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_mem[wr_index] <= wr_data_clean;
    end
  end

  // Only the bitmap is reset; clearing it is what makes old contents invisible.
  always_ff @(posedge clk) begin
    if (reset) begin
      written_reg <= '0;
    end else if (wr_en) begin
      written_reg[wr_index] <= 1'b1;
    end
  end

  assign rd_index = rd_block[DEPTH_LOG2-1:0];
  assign rd_data  = written_reg[rd_index] ? line_mem[rd_index]
                                          : line_pattern({rd_block, {LINE_OFS_BITS{1'b0}}});

endmodule

// File: rtl/dram_backing_store.sv
// DRAM model answering the L2 backing-store port: one held request, fixed
// programmable latency, single-cycle ready pulse, plus access statistics.
module dram_backing_store
  import dram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dram_valid,
  input  logic                 dram_write,
  input  logic [31:0]          dram_addr,
  input  logic [LINE_BITS-1:0] dram_wdata,
  output logic [LINE_BITS-1:0] dram_rdata,
  output logic                 dram_ready,
  output logic                 busy,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count,
  output logic                 alias_err
);

  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int BLK_W   = 32 - LINE_OFS_BITS;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

  if (RD_LATENCY < 1) begin : g_rd_lat_check
    $error("RD_LATENCY must be at least 1");
  end
  if (WR_LATENCY < 1) begin : g_wr_lat_check
    $error("WR_LATENCY must be at least 1");
  end

  dram_state_t          state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 write_reg;
  logic [BLK_W-1:0]     block_reg;
  logic                 accept;
  logic                 load_rdata;
  logic                 alias_hit;
  logic [BLK_W-1:0]     rd_block_sel;
  logic [LINE_BITS-1:0] store_rdata;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^dram_addr[LINE_OFS_BITS-1:0];

  if (LINE_OFS_BITS + DEPTH_LOG2 < 32) begin : g_alias
    assign alias_hit = |dram_addr[31:LINE_OFS_BITS+DEPTH_LOG2];
  end else begin : g_no_alias
    assign alias_hit = 1'b0;
  end

  // The counter holds remaining BUSY cycles; RESP is entered as it would hit 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    load_rdata = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dram_valid === 1'b1) begin
          accept   = 1'b1;
          cnt_next = dram_write ? WR_LOAD : RD_LOAD;
          if (cnt_next == '0) begin
            state_next = RESP;
            load_rdata = !dram_write;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = RESP;
          load_rdata = !write_reg;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A latency-1 read loads data at acceptance, so look up the incoming address in IDLE.
  assign rd_block_sel = (state_reg == IDLE) ? dram_addr[31:LINE_OFS_BITS] : block_reg;

  dram_line_store #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_line_store (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (accept && dram_write),
    .wr_index (dram_addr[LINE_OFS_BITS +: DEPTH_LOG2]),
    .wr_data  (dram_wdata),
    .rd_block (rd_block_sel),
    .rd_data  (store_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      write_reg  <= 1'b0;
      block_reg  <= '0;
      dram_rdata <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
      alias_err  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        write_reg <= dram_write;
        block_reg <= dram_addr[31:LINE_OFS_BITS];
        if (dram_write) begin
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end else begin
          if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
        if (alias_hit) alias_err <= 1'b1;
      end
      if (load_rdata) begin
        dram_rdata <= store_rdata;
      end
    end
  end

  assign dram_ready = (state_reg == RESP);
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_dram_backing_store.sv
// Randomized bench for dram_backing_store against a line-level reference model
// (associative memory of written lines, counters, sticky alias flag).
module tb_dram_backing_store;

  localparam int DEPTH_LOG2 = 10;
  localparam int RD_LAT     = 4;
  localparam int WR_LAT     = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         dram_valid;
  logic         dram_write;
  logic [31:0]  dram_addr;
  logic [127:0] dram_wdata;
  logic [127:0] dram_rdata;
  logic         dram_ready;
  logic         busy;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
  logic         alias_err;

  dram_backing_store #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .RD_LATENCY(RD_LAT),
    .WR_LATENCY(WR_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .dram_valid (dram_valid),
    .dram_write (dram_write),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .dram_ready (dram_ready),
    .busy       (busy),
    .rd_count   (rd_count),
    .wr_count   (wr_count),
    .alias_err  (alias_err)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int txn        = 0;

  logic [127:0] mdl_mem [int];
  int           mdl_rd;
  int           mdl_wr;
  bit           mdl_alias;
  logic [127:0] mdl_rdata;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] expect_line(input logic [31:0] addr);
    int idx;
    logic [31:0] blk;
    idx = int'(addr[4 +: DEPTH_LOG2]);
    if (mdl_mem.exists(idx)) return mdl_mem[idx];
    blk = {addr[31:4], 4'h0};
    return {blk, blk, blk, blk};
  endfunction

  task automatic model_reset();
    mdl_mem.delete();
    mdl_rd    = 0;
    mdl_wr    = 0;
    mdl_alias = 0;
    mdl_rdata = '0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_rdata"}, dram_rdata, mdl_rdata);
    check({tag, "_rd_count"}, rd_count, 128'(mdl_rd));
    check({tag, "_wr_count"}, wr_count, 128'(mdl_wr));
    check({tag, "_alias"}, alias_err, mdl_alias);
  endtask

  // Called at posedge+1 in an IDLE cycle. noise: 0 none, 1 random, 2 always
  // (valid pulses with junk during BUSY/RESP which must be ignored).
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [127:0] data,
                        input int noise);
    int lat;
    logic [127:0] exp_rd;
    lat = wr ? WR_LAT : RD_LAT;
    exp_rd = '0;
    if (wr) begin
      mdl_mem[int'(addr[4 +: DEPTH_LOG2])] = data;
      if (mdl_wr != 65535) mdl_wr++;
    end else begin
      exp_rd = expect_line(addr);
      if (mdl_rd != 65535) mdl_rd++;
    end
    if (addr[31:4+DEPTH_LOG2] != 0) mdl_alias = 1;
    dram_valid = 1'b1;
    dram_write = wr;
    dram_addr  = addr;
    dram_wdata = data;
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk);
      #1;
      dram_valid = 1'b0;
      check($sformatf("ready_c%0d", c), dram_ready, (c == lat));
      check($sformatf("busy_c%0d", c), busy, (c <= lat));
      if (c == lat && !wr) begin
        check("read_data", dram_rdata, exp_rd);
        mdl_rdata = exp_rd;
      end
      if (c <= lat && (noise == 2 || (noise == 1 && $urandom_range(0, 1) == 1))) begin
        dram_valid = 1'b1;
        dram_write = 1'($urandom);
        dram_addr  = $urandom;
        dram_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    check_state("post");
    txn++;
    $display("txn %0d: %s addr=%h rd_count=%0d wr_count=%0d alias=%0b",
             txn, wr ? "WR" : "RD", addr, rd_count, wr_count, alias_err);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] d1;
    logic [127:0] d2;
    reset      = 1'b1;
    dram_valid = 1'b0;
    dram_write = 1'b0;
    dram_addr  = '0;
    dram_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", dram_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check_state("rst");

    // Read of an unwritten line returns the address pattern after RD_LAT cycles.
    do_req(1'b0, 32'h0000_1230, '0, 0);
    check("tp_read_pattern", dram_rdata, 128'h00001230_00001230_00001230_00001230);

    // Write then read back from a different byte offset in the same line.
    d1 = 128'hDEADBEEF_00000000_00000000_CAFEF00D;
    do_req(1'b1, 32'h0000_0040, d1, 0);
    do_req(1'b0, 32'h0000_004C, '0, 0);
    check("tp_write_readback", dram_rdata, d1);

    // Valid pulses during BUSY and RESP are ignored.
    do_req(1'b0, 32'h0000_0040, '0, 2);

    // Valid held high: a new write is accepted every WR_LAT+1 cycles.
    d2 = {$urandom, $urandom, $urandom, $urandom};
    dram_valid = 1'b1;
    dram_write = 1'b1;
    dram_addr  = 32'h0000_0080;
    dram_wdata = d2;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold_ready_c%0d", c), dram_ready, (c % 3 == 2));
      if (c == 9) dram_valid = 1'b0;
    end
    mdl_wr += 3;
    mdl_mem[8] = d2;
    check_state("hold");
    do_req(1'b0, 32'h0000_0080, '0, 0);

    // Reset while a read is in BUSY aborts it and discards the committed write.
    do_req(1'b1, 32'h0000_0100, {4{32'h1234_5678}}, 0);
    dram_valid = 1'b1;
    dram_write = 1'b0;
    dram_addr  = 32'h0000_0100;
    @(posedge clk);
    #1;
    dram_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("midrst_busy", busy, 1'b0);
    check_state("midrst");
    for (int c = 0; c < RD_LAT; c++) begin
      check($sformatf("midrst_noready_%0d", c), dram_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    do_req(1'b0, 32'h0000_0100, '0, 0);
    check("midrst_pattern", dram_rdata, 128'h00000100_00000100_00000100_00000100);

    // Address with bits above the index sets the sticky alias flag.
    do_req(1'b0, 32'h0001_0010, '0, 0);
    check("alias_set", alias_err, 1'b1);
    check("alias_pattern", dram_rdata, 128'h00010010_00010010_00010010_00010010);

    // Random mix over a small set of lines so reads hit earlier writes.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = {18'd0, 6'($urandom_range(0, 15)), 4'($urandom)};
      a[DEPTH_LOG2+3:4] = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) a[31:14] = 18'($urandom);
      do_req(1'($urandom), a, {$urandom, $urandom, $urandom, $urandom}, 1);
    end
    check("alias_sticky", alias_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
